// File: rtl/clk_pll_emu.sv
// clk_pll_emu: reconfigurable PLL emulator.
// Derives NumPlls divided clocks plus a free-running real-time clock from clk_i.
// Each channel has its own divider and a lock indicator that models relock time.
module clk_pll_emu #(
  parameter  int unsigned NumPlls    = 3,
  parameter  int unsigned DivWidth   = 8,
  parameter  int unsigned DefaultDiv = 1,
  parameter  int unsigned LockCycles = 16,
  parameter  int unsigned RtDiv      = 50,
  localparam int unsigned IdxWidth   = (NumPlls > 1) ? $clog2(NumPlls) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [IdxWidth-1:0] cfg_idx_i,
  input  logic [DivWidth-1:0] cfg_div_i,
  output logic [NumPlls-1:0]  clk_pll_o,
  output logic [NumPlls-1:0]  lock_o,
  output logic                rt_clk_o
);

  localparam int unsigned LcntWidth = $clog2(LockCycles + 1);
  localparam int unsigned RtWidth   = (RtDiv > 1) ? $clog2(RtDiv) : 1;
  localparam int unsigned PadPlls   = 2 ** IdxWidth;

  if (LockCycles < 1) begin : g_lock_cycles_check
    $error("clk_pll_emu: LockCycles must be >= 1");
  end
  if (RtDiv < 1) begin : g_rt_div_check
    $error("clk_pll_emu: RtDiv must be >= 1");
  end
  if ((DefaultDiv < 1) || (DefaultDiv >= (2 ** DivWidth))) begin : g_default_div_check
    $error("clk_pll_emu: DefaultDiv out of range");
  end

  // A divider of 0 has no meaningful period, so it is treated as 1.
  function automatic logic [DivWidth-1:0] sanitize_div(input logic [DivWidth-1:0] div);
    return (div == '0) ? DivWidth'(1) : div;
  endfunction

  logic [DivWidth-1:0]  div_q  [NumPlls];
  logic [DivWidth-1:0]  div_d  [NumPlls];
  logic [DivWidth-1:0]  cnt_q  [NumPlls];
  logic [DivWidth-1:0]  cnt_d  [NumPlls];
  logic [LcntWidth-1:0] lcnt_q [NumPlls];
  logic [LcntWidth-1:0] lcnt_d [NumPlls];
  logic [NumPlls-1:0]   clk_q, clk_d;
  logic [NumPlls-1:0]   lock_q, lock_d;

  logic [RtWidth-1:0]   rt_cnt_q, rt_cnt_d;
  logic                 rt_clk_q, rt_clk_d;

  logic                 idx_in_range;
  logic [PadPlls-1:0]   lock_pad;
  logic                 accept;

  assign idx_in_range = ({1'b0, cfg_idx_i} < (IdxWidth + 1)'(NumPlls));

  // Zero-pad the lock vector so any index value selects a defined bit.
  always_comb begin
    lock_pad              = '0;
    lock_pad[NumPlls-1:0] = lock_q;
  end

  assign cfg_ready_o = idx_in_range ? lock_pad[cfg_idx_i] : 1'b1;
  assign accept      = cfg_valid_i & cfg_ready_o;

  // Per-channel next state: reconfigure on accept, otherwise lock countdown or divide.
  always_comb begin
    for (int unsigned i = 0; i < NumPlls; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      lcnt_d[i] = lcnt_q[i];
      clk_d[i]  = clk_q[i];
      lock_d[i] = lock_q[i];
      if (accept && idx_in_range && (cfg_idx_i == IdxWidth'(i))) begin
        div_d[i]  = sanitize_div(cfg_div_i);
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        lock_d[i] = 1'b0;
        lcnt_d[i] = LcntWidth'(LockCycles);
      end else if (!lock_q[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (lcnt_q[i] == LcntWidth'(1)) begin
          lock_d[i] = 1'b1;
          lcnt_d[i] = '0;
        end else begin
          lcnt_d[i] = lcnt_q[i] - LcntWidth'(1);
        end
      end else if ((cnt_q[i] + DivWidth'(1)) == div_q[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = ~clk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DivWidth'(1);
      end
    end
  end

  // Real-time clock: toggles every RtDiv reference cycles, never disturbed by config.
  always_comb begin
    rt_cnt_d = rt_cnt_q + RtWidth'(1);
    rt_clk_d = rt_clk_q;
    if (rt_cnt_q == RtWidth'(RtDiv - 1)) begin
      rt_cnt_d = '0;
      rt_clk_d = ~rt_clk_q;
    end
  end

  // State registers; reset puts every channel into a fresh relock at DefaultDiv.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumPlls; i++) begin
        div_q[i]  <= DivWidth'(DefaultDiv);
        cnt_q[i]  <= '0;
        lcnt_q[i] <= LcntWidth'(LockCycles);
      end
      clk_q    <= '0;
      lock_q   <= '0;
      rt_cnt_q <= '0;
      rt_clk_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      clk_q    <= clk_d;
      lock_q   <= lock_d;
      rt_cnt_q <= rt_cnt_d;
      rt_clk_q <= rt_clk_d;
    end
  end

  assign clk_pll_o = clk_q;
  assign lock_o    = lock_q;
  assign rt_clk_o  = rt_clk_q;

endmodule

// File: tb/tb_clk_pll_emu.sv
// Testbench for clk_pll_emu: scenario table, hand-written corner sequences and
// random configuration traffic compared against a timing-formula reference model.
module tb_clk_pll_emu;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int DDIV = 1;
  localparam int L    = 16;
  localparam int RT   = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_idx = 2'd0;
  logic [DW-1:0] cfg_div = '0;
  logic [N-1:0] clk_pll;
  logic [N-1:0] lock;
  logic         rt_clk;

  clk_pll_emu #(
    .NumPlls   (N),
    .DivWidth  (DW),
    .DefaultDiv(DDIV),
    .LockCycles(L),
    .RtDiv     (RT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_idx_i  (cfg_idx),
    .cfg_div_i  (cfg_div),
    .clk_pll_o  (clk_pll),
    .lock_o     (lock),
    .rt_clk_o   (rt_clk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel remembers the edge of its last (re)start and its divider.
  int n;
  int t0   [N];
  int mdiv [N];
  bit dut_rdy;

  typedef struct {
    int idx;
    int div;
    int exp_lowcnt;
    int exp_half;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, n, act, exp);
    end
  endtask

  function automatic bit m_lock(input int c);
    return (n - t0[c]) >= L;
  endfunction

  function automatic bit m_clk(input int c);
    int e;
    e = n - t0[c];
    if (e < L) return 1'b0;
    return (((e - L) / mdiv[c]) % 2) == 1;
  endfunction

  function automatic bit m_rt();
    return ((n / RT) % 2) == 1;
  endfunction

  function automatic bit m_ready(input int idx);
    if (idx >= N) return 1'b1;
    return m_lock(idx);
  endfunction

  // Packed like {clk_pll, lock, rt_clk}.
  function automatic int m_outs();
    int v;
    v = 0;
    for (int c = 0; c < N; c++) begin
      v = v | (int'(m_clk(c)) << (4 + c));
      v = v | (int'(m_lock(c)) << (1 + c));
    end
    v = v | int'(m_rt());
    return v;
  endfunction

  // One reference cycle: called at a falling edge with inputs already driven.
  task automatic tick();
    bit acc;
    int ix;
    #1;
    ix = int'(cfg_idx);
    dut_rdy = cfg_ready;
    check("cfg_ready", int'(cfg_ready), int'(m_ready(ix)));
    acc = cfg_valid && m_ready(ix);
    @(posedge clk);
    n++;
    if (acc && ix < N) begin
      t0[ix]   = n;
      mdiv[ix] = (cfg_div == 0) ? 1 : int'(cfg_div);
    end
    @(negedge clk);
    check("outputs", int'({clk_pll, lock, rt_clk}), m_outs());
  endtask

  // Asserts reset between edges, checks the asynchronous clear, holds, releases at a falling edge.
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", int'({clk_pll, lock, rt_clk}), 0);
    check("reset_ready", int'(cfg_ready), (int'(cfg_idx) < N) ? 0 : 1);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < N; c++) begin
      t0[c]   = 0;
      mdiv[c] = DDIV;
    end
  endtask

  task automatic wait_ready(input int idx);
    int k;
    cfg_idx = 2'(idx);
    k = 0;
    #1;
    while (!cfg_ready && k < 2000) begin
      tick();
      k++;
      #1;
    end
    if (!cfg_ready) check("ready_wait_timeout", int'(cfg_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e, hi, lo, idx, r;

    tbl[0] = '{idx: 1, div: 5,   exp_lowcnt: 16, exp_half: 5};
    tbl[1] = '{idx: 0, div: 0,   exp_lowcnt: 16, exp_half: 1};
    tbl[2] = '{idx: 2, div: 255, exp_lowcnt: 16, exp_half: 255};
    tbl[3] = '{idx: 3, div: 7,   exp_lowcnt: 0,  exp_half: 0};
    tbl[4] = '{idx: 1, div: 2,   exp_lowcnt: 16, exp_half: 2};

    n = 0;
    @(negedge clk);
    do_reset(2);

    // Reset release: lock after 16 edges, first divided rise at 17, rt rise at 50.
    k = 0;
    while (lock != 3'b111 && k < 100) begin
      tick();
      k++;
    end
    check("lock_after_reset", k, L);
    tick();
    check("clk_first_rise", int'(clk_pll), 7);
    while (rt_clk == 1'b0 && n < 300) tick();
    check("rt_first_rise", n, RT);
    while (rt_clk == 1'b1 && n < 300) tick();
    check("rt_first_fall", n, 2 * RT);

    // Scenario table: reconfigure, measure relock length, first rise and phase lengths.
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b0;
      cfg_div   = DW'(tbl[i].div);
      wait_ready(tbl[i].idx);
      cfg_valid = 1'b1;
      tick();
      check("tbl_accept_ready", int'(dut_rdy), 1);
      cfg_valid = 1'b0;
      if (tbl[i].idx >= N) begin
        check("oor_lock", int'(lock), 7);
      end else begin
        idx = tbl[i].idx;
        e  = 0;
        lo = 0;
        while (lock[idx] == 1'b0 && lo < 100) begin
          check("clk_held_in_relock", int'(clk_pll[idx]), 0);
          lo++;
          tick();
          e++;
        end
        check("relock_len", lo, tbl[i].exp_lowcnt);
        while (clk_pll[idx] == 1'b0 && e < 2000) begin
          tick();
          e++;
        end
        check("first_rise_edge", e, tbl[i].exp_lowcnt + tbl[i].exp_half);
        hi = 0;
        while (clk_pll[idx] == 1'b1 && hi < 1000) begin
          hi++;
          tick();
        end
        check("high_phase", hi, tbl[i].exp_half);
        lo = 0;
        while (clk_pll[idx] == 1'b0 && lo < 1000) begin
          lo++;
          tick();
        end
        check("low_phase", lo, tbl[i].exp_half);
      end
    end

    // Request held through a relock is accepted on the cycle lock returns.
    cfg_div = DW'(5);
    wait_ready(1);
    cfg_valid = 1'b1;
    tick();
    check("hold_first_accept", int'(dut_rdy), 1);
    cfg_div = DW'(3);
    k = 0;
    do begin
      tick();
      k++;
    end while (!dut_rdy && k < 100);
    check("held_accept_edge", k, L + 1);
    cfg_valid = 1'b0;
    lo = 0;
    while (lock[1] == 1'b0 && lo < 100) begin
      lo++;
      tick();
    end
    check("second_relock_len", lo, L);

    // Reset in the middle of channel 2's relock (lock counter at 7).
    cfg_div = DW'(4);
    wait_ready(2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (L - 7) tick();
    do_reset(3);
    k = 0;
    while (lock != 3'b111 && k < 100) begin
      tick();
      k++;
    end
    check("relock_after_mid_reset", k, L);
    tick();
    check("default_div_after_reset", int'(clk_pll), 7);

    // Random configuration traffic.
    for (int i = 0; i < 10000; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_idx   = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 15));
      if (r == 15) cfg_div = DW'($urandom_range(16, 40));
      else         cfg_div = DW'(r);
      tick();
    end
    cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_pll_emu.md
# clk_pll_emu

Parametrised, reconfigurable PLL emulator for RTL simulation and FPGA bring-up. It derives `NumPlls` independent divided clocks and one real-time clock from a single reference clock. Each channel has a per-channel divider, programmed through a valid/ready configuration port, and a lock indicator that models PLL relock time. It sits in the testbench/FPGA clocking layer and replaces free-running ideal oscillators. This lets SoC clock-domain logic be exercised across frequency changes and lock loss.

## Interface
Parameters:
- `NumPlls`, 3: number of output clock channels (>= 1).
- `DivWidth`, 8: width of the divider value; max divider 2^DivWidth-1.
- `DefaultDiv`, 1: divider loaded into every channel at reset (1..2^DivWidth-1).
- `LockCycles`, 16: relock duration in `clk_i` cycles (>= 1; elaboration assertion).
- `RtDiv`, 50: half-period of `rt_clk_o` in `clk_i` cycles (>= 1).
- `IdxWidth`, derived: `NumPlls > 1 ? $clog2(NumPlls) : 1`.

Ports:
- `clk_i`, in, 1: reference clock; all state is clocked on its rising edge.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `cfg_valid_i`, in, 1: configuration request.
- `cfg_ready_o`, out, 1: configuration can be accepted.
- `cfg_idx_i`, in, IdxWidth: target channel.
- `cfg_div_i`, in, DivWidth: new divider for the target channel.
- `clk_pll_o`, out, NumPlls: divided clocks. Each output is a register output, with period 2*div `clk_i` cycles and 50% duty.
- `lock_o`, out, NumPlls: per-channel lock status.
- `rt_clk_o`, out, 1: free-running real-time clock, period 2*RtDiv `clk_i` cycles.

## Operation
- Per-channel state:
  - `div_q` (DivWidth)
  - phase counter `cnt_q` (DivWidth)
  - output register `clk_q`
  - `lock_q`
  - lock counter `lcnt_q` (`$clog2(LockCycles+1)` bits)
- Channel states: LOCKING (`lock_q`=0) and LOCKED (`lock_q`=1).
- LOCKING behaviour:
  - `clk_q` is held at 0 and `cnt_q` at 0.
  - `lcnt_q` decrements each cycle.
  - When `lcnt_q`==1, the channel sets `lock_q`, moves to LOCKED and loads `lcnt_q` to 0.
- LOCKED behaviour:
  - When `cnt_q`==`div_q`-1: `cnt_q` returns to 0 and `clk_q` toggles.
  - Otherwise `cnt_q` increments.
- Handshake:
  - `cfg_ready_o` = `lock_o[cfg_idx_i]` when `cfg_idx_i` < NumPlls; otherwise 1. It is combinational and independent of `cfg_valid_i`.
  - Accept = `cfg_valid_i` & `cfg_ready_o`.
- On accept to an in-range channel:
  - `div_q` <= `cfg_div_i`; the value 0 is stored as 1.
  - `cnt_q` <= 0, `clk_q` <= 0, `lock_q` <= 0, `lcnt_q` <= LockCycles.
  - The channel enters LOCKING. Writing the current divider still triggers a relock.
- On accept to an out-of-range `cfg_idx_i`: the request is consumed and ignored; no state changes.
- Only one channel can be reconfigured per cycle. A channel cannot be reconfigured while it is LOCKING (ready low).
- `rt_clk_o` counter:
  - Counts 0..RtDiv-1 and toggles at RtDiv-1.
  - Unaffected by configuration and lock state.
- Reset (asynchronous, at any time, including mid-relock):
  - Every channel: `div_q`=DefaultDiv, `cnt_q`=0, `clk_q`=0, `lock_q`=0, `lcnt_q`=LockCycles. All channels then relock.
  - RT counter=0, `rt_clk_o`=0.
  - Outputs immediately: `clk_pll_o`=0, `lock_o`=0, `rt_clk_o`=0.
  - `cfg_ready_o`=0 for in-range `cfg_idx_i`; 1 for out-of-range `cfg_idx_i`.

## Timing
- Edges are numbered from the accept edge (edge 0), or from the first rising edge after `rst_ni` release (edge 1).
- After an accept at edge 0:
  - `lock_o` falls and `clk_pll_o` is forced low after edge 0.
  - `lock_o` rises after edge LockCycles.
  - First `clk_pll_o` rising edge is after edge LockCycles+div; it toggles every div edges from then on.
- After reset release:
  - `lock_o` rises after edge LockCycles.
  - First `clk_pll_o` rise is after edge LockCycles+DefaultDiv.
  - First `rt_clk_o` rise is after edge RtDiv.
- `cfg_ready_o` for a channel goes low the cycle after its accept and returns high together with `lock_o`.
- Channels are fully independent. Relocking one channel never perturbs the phase of another channel or of `rt_clk_o`.

## Test plan
- Reset release with default parameters: `lock_o`=3'b000 until edge 16, then 3'b111. Each `clk_pll_o` bit rises at edge 17 with period 2 cycles. `rt_clk_o` rises at edge 50 with period 100.
- Configure channel 1 with div=5 while locked:
  - `lock_o[1]` low for exactly 16 cycles and `clk_pll_o[1]` held 0.
  - `clk_pll_o[1]` rises at edge 21 with period 10, high 5 / low 5.
  - Channels 0 and 2 keep toggling with no phase change.
- Second `cfg_valid_i` to channel 1 during its relock: `cfg_ready_o`=0 and the request is held. Acceptance occurs on the cycle `lock_o[1]` rises, and a fresh 16-cycle relock follows.
- Edge values:
  - `cfg_div_i`=0: behaves as div=1 (period 2).
  - `cfg_div_i`=255: period 510.
  - `cfg_idx_i`=3: accepted with ready=1, no channel changes.
- Assert `rst_ni` low mid-relock of channel 2 (`lcnt_q`=7) for 3 cycles:
  - All outputs go to 0 asynchronously.
  - After release, all three channels relock in 16 cycles with div=DefaultDiv.
- Random config traffic over 10k cycles, checked against a reference model:
  - Every high/low phase of `clk_pll_o` equals the programmed div while locked.
  - No `clk_pll_o` activity while `lock_o` is low.
